// File: rtl/lsu_load_unit.sv
// Memory-stage load engine: one outstanding aligned read; the result is extracted, extended and held for writeback.
// Latency is 3 cycles from accept to load_valid (1 cycle for a fault that needs no bus access); every handshake may stall.
module lsu_load_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  input  logic [4:0]      req_rd,
  output logic            mem_ar_valid,
  input  logic            mem_ar_ready,
  output logic [XLEN-1:0] mem_ar_addr,
  input  logic            mem_r_valid,
  output logic            mem_r_ready,
  input  logic [XLEN-1:0] mem_r_data,
  input  logic            mem_r_err,
  output logic            load_valid,
  input  logic            load_ready,
  output logic [XLEN-1:0] load_data,
  output logic [4:0]      load_rd,
  output logic            load_fault,
  output logic [1:0]      load_cause
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_MISALGN = 2'd1;
  localparam logic [1:0] CAUSE_ACCESS  = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd3;

  state_t          state, state_d;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] data_q;
  logic [1:0]      cause_q;

  logic            accept;
  logic            beat;
  logic            req_illegal;
  logic            req_misaligned;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] extracted;

  // Request screening: funct3[1:0] encodes the access size for every legal load.
  always_comb begin
    req_illegal    = (req_funct3 == 3'b111);
    req_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
      2'b11:   req_misaligned = (req_addr[2:0] != 3'b000);
      default: req_misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d      = state;
    req_ready    = 1'b0;
    mem_ar_valid = 1'b0;
    mem_r_ready  = 1'b0;
    load_valid   = 1'b0;
    accept       = 1'b0;
    beat         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (req_illegal || req_misaligned) ? DONE : ADDR;
        end
      end
      ADDR: begin
        mem_ar_valid = 1'b1;
        if (mem_ar_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        mem_r_ready = 1'b1;
        if (mem_r_valid) begin
          beat    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        load_valid = 1'b1;
        if (load_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bring the addressed bytes down to bit 0, then extend by access type.
  always_comb begin
    shifted   = mem_r_data >> {addr_q[2:0], 3'b000};
    extracted = '0;
    case (funct3_q)
      3'b000:  extracted = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  extracted = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  extracted = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b011:  extracted = shifted;
      3'b100:  extracted = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  extracted = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  extracted = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: extracted = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      funct3_q <= 3'b000;
      rd_q     <= 5'd0;
      data_q   <= '0;
      cause_q  <= CAUSE_NONE;
    end else if (accept) begin
      addr_q   <= req_addr;
      funct3_q <= req_funct3;
      rd_q     <= req_rd;
      data_q   <= '0;
      if (req_illegal) begin
        cause_q <= CAUSE_ILLEGAL;
      end else if (req_misaligned) begin
        cause_q <= CAUSE_MISALGN;
      end else begin
        cause_q <= CAUSE_NONE;
      end
    end else if (beat) begin
      if (mem_r_err) begin
        cause_q <= CAUSE_ACCESS;
        data_q  <= '0;
      end else begin
        data_q  <= extracted;
      end
    end
  end

  assign mem_ar_addr = {addr_q[XLEN-1:3], 3'b000};
  assign load_data   = data_q;
  assign load_rd     = rd_q;
  assign load_fault  = (cause_q != CAUSE_NONE);
  assign load_cause  = cause_q;

  // Held payloads must not move while the consumer stalls.
  property p_ar_hold;
    @(posedge clk) disable iff (rst)
      (mem_ar_valid && !mem_ar_ready) |=> (mem_ar_valid && $stable(mem_ar_addr));
  endproperty
  a_ar_hold: assert property (p_ar_hold);

  property p_load_hold;
    @(posedge clk) disable iff (rst)
      (load_valid && !load_ready) |=>
        (load_valid && $stable(load_data) && $stable(load_rd) && $stable(load_cause));
  endproperty
  a_load_hold: assert property (p_load_hold);

endmodule
